// File: rtl/hbs_pkg.sv
// Shared definitions for the high-bit-search pipeline: stage count, index width and
// the result record passed from the search datapath to its consumers.
package hbs_pkg;

    localparam int HBS_DEF_INPUT_W = 8;

    function automatic int hbs_levels(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    function automatic int hbs_index_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    typedef struct packed {
        logic                                        found;
        logic [hbs_index_width(HBS_DEF_INPUT_W)-1:0] index;
    } hbs_result_t;

endpackage

// File: rtl/hbs_sync_fifo.sv
// Small synchronous FIFO with registered head (no fall-through) and an occupancy port.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module hbs_sync_fifo
    import hbs_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = hbs_result_t,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  T                 din,
    output T                 dout,
    output logic [LVL_W-1:0] level,
    output logic             drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full queue is only lost without one.
    assign wr_en = push & (~full | rd_en);
    assign drop  = push & full & ~rd_en;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/hbs_result_queue.sv
// Result capture for the high-bit-search pipeline: tags real samples through the search
// latency, queues their aligned results and gates upstream issue with credits.
module hbs_result_queue
    import hbs_pkg::*;
#(
    parameter int  INPUT_WIDTH = 8,
    parameter int  LATENCY     = hbs_levels(INPUT_WIDTH),
    parameter int  DEPTH       = 4,
    parameter bit  DROP_EMPTY  = 1'b0,
    localparam int INDEX_WIDTH = hbs_index_width(INPUT_WIDTH),
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic                   res_found,
    input  logic [INDEX_WIDTH-1:0] res_index,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_found,
    output logic [INDEX_WIDTH-1:0] m_index,
    output logic [LVL_W-1:0]       level,
    output logic                   overflow
);

    typedef struct packed {
        logic                   found;
        logic [INDEX_WIDTH-1:0] index;
    } result_t;

    logic [LATENCY-1:0] tag;
    logic [LVL_W-1:0]   inflight;
    logic [LVL_W:0]     credits_used;
    logic               accept;
    logic               res_strobe;
    logic               push;
    logic               pop;
    logic               fifo_drop;
    result_t            res_in;
    result_t            head;

    // Credits come from registered state only; a pop returns its credit one cycle later.
    assign credits_used = {1'b0, level} + {1'b0, inflight};
    assign issue_ready  = (credits_used < (LVL_W + 1)'(DEPTH));
    assign accept       = issue_valid & issue_ready;

    // Issue stage -> result stage: the tag mirrors which search-pipeline slots hold real samples.
    assign res_strobe   = tag[LATENCY-1];
    assign push         = res_strobe & (res_found | ~DROP_EMPTY);
    assign pop          = m_valid & m_ready;
    assign res_in.found = res_found;
    assign res_in.index = res_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag      <= '0;
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            tag <= (tag << 1) | LATENCY'(accept);
            if (accept & ~res_strobe) begin
                inflight <= inflight + 1'b1;
            end else if (~accept & res_strobe) begin
                inflight <= inflight - 1'b1;
            end
            overflow <= overflow | (issue_valid & ~issue_ready) | fifo_drop;
        end
    end

    // Result stage -> output stream.
    hbs_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (result_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (res_in),
        .dout  (head),
        .level (level),
        .drop  (fifo_drop)
    );

    assign m_valid = (level != '0);
    assign m_found = head.found;
    assign m_index = head.index;

endmodule

// File: tb/tb_hbs_result_queue.sv
// Randomized and directed bench for hbs_result_queue; two instances (keep / drop empty results)
// run side by side against a cycle-stamped queue model.
module tb_hbs_result_queue;
    import hbs_pkg::*;

    localparam int W     = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int IW    = 3;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          res_found = 1'b0;
    logic [IW-1:0] res_index = '0;
    logic          ir [2];
    logic          mv [2];
    logic          mf [2];
    logic          ov [2];
    logic [IW-1:0] mi [2];
    logic [LW-1:0] lvl [2];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 64;
    int smp [64];
    bit acc [2][64];
    int mq  [2][DEPTH+1];
    int mcnt [2];
    bit mov  [2];

    always #5 clk = ~clk;

    hbs_result_queue #(.INPUT_WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH), .DROP_EMPTY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ir[0]),
        .res_found(res_found), .res_index(res_index), .m_valid(mv[0]), .m_ready(m_ready),
        .m_found(mf[0]), .m_index(mi[0]), .level(lvl[0]), .overflow(ov[0]));

    hbs_result_queue #(.INPUT_WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH), .DROP_EMPTY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ir[1]),
        .res_found(res_found), .res_index(res_index), .m_valid(mv[1]), .m_ready(m_ready),
        .m_found(mf[1]), .m_index(mi[1]), .level(lvl[1]), .overflow(ov[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Samples accepted in the last LAT cycles are still inside the search pipeline.
    function automatic int inflight(input int d);
        int n = 0;
        for (int k = 1; k <= LAT; k++) begin
            if (acc[d][(cyc - k) % 64]) n++;
        end
        return n;
    endfunction

    function automatic bit model_ready(input int d);
        return (mcnt[d] + inflight(d)) < DEPTH;
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 32'(ir[d]), 32'(model_ready(d)));
            chk($sformatf("valid%0d", d), 32'(mv[d]), 32'(mcnt[d] > 0));
            chk($sformatf("level%0d", d), 32'(lvl[d]), mcnt[d]);
            chk($sformatf("ovf%0d", d), 32'(ov[d]), 32'(mov[d]));
            if (mcnt[d] > 0) begin
                chk($sformatf("found%0d", d), 32'(mf[d]), (mq[d][0] >> 3) & 1);
                chk($sformatf("index%0d", d), 32'(mi[d]), mq[d][0] & 7);
            end
        end
    endtask

    task automatic cycle(input bit v, input bit r, input bit f, input int idx);
        int s;
        bit rdy, strobe, push, pop;
        s = smp[(cyc - LAT) % 64];
        smp[cyc % 64] = (f ? 8 : 0) + (idx & 7);
        issue_valid = v;
        m_ready     = r;
        res_found   = s[3];
        res_index   = s[2:0];
        for (int d = 0; d < 2; d++) begin
            rdy    = model_ready(d);
            strobe = acc[d][(cyc - LAT) % 64];
            push   = strobe && (s[3] || d == 0);
            pop    = (mcnt[d] > 0) && r;
            if (v && !rdy) mov[d] = 1'b1;
            if (pop) begin
                for (int k = 0; k < DEPTH; k++) mq[d][k] = mq[d][k+1];
                mcnt[d]--;
            end
            if (push) begin
                if (mcnt[d] == DEPTH) mov[d] = 1'b1;
                else begin
                    mq[d][mcnt[d]] = s & 15;
                    mcnt[d]++;
                end
            end
            acc[d][cyc % 64] = v && rdy;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input bit r);
        cycle(1'b0, r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid%0d", d), 32'(mv[d]), 0);
            chk($sformatf("rst_level%0d", d), 32'(lvl[d]), 0);
        end
        issue_valid = 1'b0;
        m_ready     = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            mov[d]  = 1'b0;
            for (int k = 0; k < 64; k++) acc[d][k] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        #2;
        do_reset();
        chk("reset_ready", 32'(ir[0]), 1);
        chk("reset_ovf", 32'(ov[0]), 0);

        // single issue: result at +3, visible at +4, then held
        cycle(1'b1, 1'b0, 1'b1, 5);
        idle(1'b0);
        idle(1'b0);
        chk("lat_early_valid", 32'(mv[0]), 0);
        idle(1'b0);
        chk("lat_valid", 32'(mv[0]), 1);
        chk("lat_index", 32'(mi[0]), 5);
        chk("lat_found", 32'(mf[0]), 1);
        repeat (3) idle(1'b0);
        chk("hold_index", 32'(mi[0]), 5);
        chk("hold_level", 32'(lvl[0]), 1);
        repeat (2) idle(1'b1);
        chk("drained", 32'(lvl[0]), 0);

        // four back-to-back issues fill every credit
        repeat (4) cycle(1'b1, 1'b0, 1'b1, int'($urandom_range(0, 7)));
        chk("burst_ready", 32'(ir[0]), 0);
        repeat (3) idle(1'b0);
        chk("full_level", 32'(lvl[0]), 4);
        chk("full_ready", 32'(ir[0]), 0);
        chk("full_ovf", 32'(ov[0]), 0);
        idle(1'b1);
        chk("pop_level", 32'(lvl[0]), 3);
        chk("pop_ready", 32'(ir[0]), 1);

        // issue without a credit
        cycle(1'b1, 1'b0, 1'b1, 2);
        cycle(1'b1, 1'b0, 1'b1, 6);
        chk("ovf_set", 32'(ov[0]), 1);
        repeat (3) idle(1'b0);
        chk("ovf_level", 32'(lvl[0]), 4);
        repeat (5) idle(1'b1);
        chk("ovf_sticky", 32'(ov[0]), 1);

        // empty results dropped by the DROP_EMPTY instance
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1);
        cycle(1'b1, 1'b0, 1'b1, 4);
        cycle(1'b1, 1'b0, 1'b0, 7);
        repeat (4) idle(1'b0);
        chk("drop_level", 32'(lvl[1]), 1);
        chk("drop_index", 32'(mi[1]), 4);
        chk("drop_ready", 32'(ir[1]), 1);
        chk("keep_level", 32'(lvl[0]), 3);
        repeat (4) idle(1'b1);

        // well-behaved random traffic
        repeat (300) begin
            cycle(($urandom_range(0, 99) < 60) & ir[0] & ir[1], $urandom_range(0, 99) < 40,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
        chk("rand_no_ovf0", 32'(ov[0]), 0);
        chk("rand_no_ovf1", 32'(ov[1]), 0);

        // reset with 2 queued and 2 in flight
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 1);
        cycle(1'b1, 1'b0, 1'b1, 2);
        idle(1'b0);
        cycle(1'b1, 1'b0, 1'b1, 3);
        cycle(1'b1, 1'b0, 1'b1, 4);
        chk("pre_rst_level", 32'(lvl[0]), 2);
        do_reset();
        repeat (5) idle(1'b0);
        chk("late_level", 32'(lvl[0]), 0);
        chk("late_valid", 32'(mv[1]), 0);

        // unconstrained random traffic, including credit violations
        repeat (300) begin
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
